// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencer: per-stage load/hold/bubble decisions for cache waits,
// load-use, mispredict redirects and multi-cycle mul/div; outputs are combinational.
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             icache_resp,
  input  logic             mem_req,
  input  logic             dcache_resp,
  input  logic             md_start,
  input  logic             ex_mispredict,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  output logic             load_pc,
  output logic             load_id,
  output logic             load_ex,
  output logic             load_mem,
  output logic             load_wb,
  output logic             bubble_id,
  output logic             bubble_ex,
  output logic             pc_redirect,
  output logic             ex_rdata_hazard,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int MD_W = $clog2(MD_LATENCY) + 1;

  logic [MD_W-1:0] md_cnt;
  logic            discard_pending;
  logic            discard_next;
  logic            md_busy, md_done, md_stall, d_stall, lu_hazard;

  assign md_busy   = (md_cnt != '0) | md_start;
  assign md_done   = ~md_start & (md_cnt == MD_W'(1));
  assign md_stall  = md_busy & ~md_done;
  assign d_stall   = mem_req & ~dcache_resp;
  assign lu_hazard = ex_is_load & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    load_pc         = 1'b0;
    load_id         = 1'b0;
    load_ex         = 1'b0;
    load_mem        = 1'b0;
    load_wb         = 1'b0;
    bubble_id       = 1'b0;
    bubble_ex       = 1'b0;
    pc_redirect     = 1'b0;
    ex_rdata_hazard = 1'b0;
    discard_next    = discard_pending;
    if (reset) begin
      discard_next = 1'b0;
    end else if (d_stall) begin
      ex_rdata_hazard = 1'b1;
    end else if (md_stall) begin
      load_wb         = 1'b1;
      ex_rdata_hazard = 1'b1;
    end else if (ex_mispredict) begin
      pc_redirect  = 1'b1;
      load_pc      = 1'b1;
      load_id      = 1'b1;
      load_ex      = 1'b1;
      load_mem     = 1'b1;
      load_wb      = 1'b1;
      bubble_id    = 1'b1;
      bubble_ex    = 1'b1;
      // The wrong-path fetch still in flight must be dropped when it returns.
      discard_next = discard_pending | ~icache_resp;
    end else if (discard_pending & icache_resp) begin
      load_id      = 1'b1;
      load_ex      = 1'b1;
      load_mem     = 1'b1;
      load_wb      = 1'b1;
      bubble_id    = 1'b1;
      discard_next = 1'b0;
    end else if (lu_hazard) begin
      load_ex   = 1'b1;
      load_mem  = 1'b1;
      load_wb   = 1'b1;
      bubble_ex = 1'b1;
    end else if (~icache_resp) begin
      load_id   = 1'b1;
      load_ex   = 1'b1;
      load_mem  = 1'b1;
      load_wb   = 1'b1;
      bubble_id = 1'b1;
    end else begin
      load_pc  = 1'b1;
      load_id  = 1'b1;
      load_ex  = 1'b1;
      load_mem = 1'b1;
      load_wb  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt          <= '0;
      discard_pending <= 1'b0;
      stall_cycles    <= '0;
    end else begin
      // The mul/div count runs regardless of which stall is currently winning.
      if (md_start && md_cnt == '0)
        md_cnt <= MD_W'(MD_LATENCY - 1);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - MD_W'(1);
      discard_pending <= discard_next;
      if (!load_pc && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl; a second narrow-counter instance covers saturation.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic icache_resp, mem_req, dcache_resp, md_start, ex_mispredict, ex_is_load;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic id_uses_rs1, id_uses_rs2;
  logic load_pc, load_id, load_ex, load_mem, load_wb, bubble_id, bubble_ex, pc_redirect, ex_rdata_hazard;
  logic [31:0] stall_cycles;
  logic s_load_pc, s_load_id, s_load_ex, s_load_mem, s_load_wb, s_bubble_id, s_bubble_ex, s_pc_redirect, s_ex_rdata_hazard;
  logic [1:0] s_stall_cycles;
  logic [8:0] ctl, s_ctl;

  int vec_cnt = 0;
  int err_cnt = 0;

  // ctl order: load_pc load_id load_ex load_mem load_wb | bubble_id bubble_ex pc_redirect ex_rdata_hazard
  localparam logic [8:0] ZERO = 9'b00000_0000;
  localparam logic [8:0] RUN  = 9'b11111_0000;
  localparam logic [8:0] DST  = 9'b00000_0001;
  localparam logic [8:0] MDS  = 9'b00001_0001;
  localparam logic [8:0] LU   = 9'b00111_0100;
  localparam logic [8:0] IST  = 9'b01111_1000;
  localparam logic [8:0] MIS  = 9'b11111_1110;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .icache_resp(icache_resp), .mem_req(mem_req),
    .dcache_resp(dcache_resp), .md_start(md_start), .ex_mispredict(ex_mispredict),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .load_pc(load_pc), .load_id(load_id), .load_ex(load_ex), .load_mem(load_mem),
    .load_wb(load_wb), .bubble_id(bubble_id), .bubble_ex(bubble_ex),
    .pc_redirect(pc_redirect), .ex_rdata_hazard(ex_rdata_hazard), .stall_cycles(stall_cycles)
  );

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .icache_resp(icache_resp), .mem_req(mem_req),
    .dcache_resp(dcache_resp), .md_start(md_start), .ex_mispredict(ex_mispredict),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .load_pc(s_load_pc), .load_id(s_load_id), .load_ex(s_load_ex), .load_mem(s_load_mem),
    .load_wb(s_load_wb), .bubble_id(s_bubble_id), .bubble_ex(s_bubble_ex),
    .pc_redirect(s_pc_redirect), .ex_rdata_hazard(s_ex_rdata_hazard), .stall_cycles(s_stall_cycles)
  );

  assign ctl   = {load_pc, load_id, load_ex, load_mem, load_wb, bubble_id, bubble_ex, pc_redirect, ex_rdata_hazard};
  assign s_ctl = {s_load_pc, s_load_id, s_load_ex, s_load_mem, s_load_wb, s_bubble_id, s_bubble_ex, s_pc_redirect, s_ex_rdata_hazard};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Sample outputs 1ns after inputs settle, then advance one clock.
  task automatic cyc(input string tag, input logic [8:0] exp_ctl, input int exp_sc);
    #1;
    check({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl));
    check({tag, "_sc"}, stall_cycles, 32'(exp_sc));
    check({tag, "_ctl2"}, 32'(s_ctl), 32'(exp_ctl));
    check({tag, "_sat"}, 32'(s_stall_cycles), (exp_sc > 3) ? 32'd3 : 32'(exp_sc));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    icache_resp   = 1'b1;
    mem_req       = 1'b0;
    dcache_resp   = 1'b0;
    md_start      = 1'b0;
    ex_mispredict = 1'b0;
    ex_is_load    = 1'b0;
    ex_rd         = 5'd0;
    id_rs1        = 5'd0;
    id_rs2        = 5'd0;
    id_uses_rs1   = 1'b0;
    id_uses_rs2   = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc("reset", ZERO, 0);
    reset = 1'b0;
    cyc("run0", RUN, 0);
    cyc("run1", RUN, 0);

    // D-cache wait: three held cycles, then release
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) cyc("dstall", DST, i);
    dcache_resp = 1'b1;
    cyc("dresp", RUN, 3);
    idle();
    cyc("d_after", RUN, 3);

    // Load-use on rs2, then on rs1; ex_rd=0 and unused source must not stall
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    cyc("lu_rs2", LU, 3);
    ex_is_load = 1'b0;
    cyc("lu_clear", RUN, 4);
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
    cyc("lu_x0", RUN, 4);
    ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0;
    cyc("lu_rs1", LU, 4);
    id_uses_rs1 = 1'b0;
    cyc("lu_unused", RUN, 5);
    idle();

    // Mul/div occupancy: 3 stall cycles then run
    md_start = 1'b1;
    cyc("md0", MDS, 5);
    md_start = 1'b0;
    cyc("md1", MDS, 6);
    cyc("md2", MDS, 7);
    cyc("md_done", RUN, 8);
    cyc("md_after", RUN, 8);

    // Mispredict with fetch outstanding: discard the late return
    ex_mispredict = 1'b1; icache_resp = 1'b0;
    cyc("mis", MIS, 8);
    ex_mispredict = 1'b0;
    cyc("mis_ist0", IST, 8);
    cyc("mis_ist1", IST, 9);
    icache_resp = 1'b1;
    cyc("discard", IST, 10);
    cyc("disc_clr", RUN, 11);

    // Mispredict with fetch returned: nothing to discard
    ex_mispredict = 1'b1;
    cyc("mis_hit", MIS, 11);
    ex_mispredict = 1'b0;
    cyc("mis_hit_nx", RUN, 11);

    // Pending discard survives a D-stall
    ex_mispredict = 1'b1; icache_resp = 1'b0;
    cyc("mis2", MIS, 11);
    ex_mispredict = 1'b0; icache_resp = 1'b1; mem_req = 1'b1;
    cyc("mis2_dst", DST, 11);
    mem_req = 1'b0;
    cyc("mis2_disc", IST, 12);
    cyc("mis2_clr", RUN, 13);

    // Mispredict ignored during mul/div, taken on the completing cycle
    md_start = 1'b1; ex_mispredict = 1'b1;
    cyc("mdmis0", MDS, 13);
    md_start = 1'b0;
    cyc("mdmis1", MDS, 14);
    cyc("mdmis2", MDS, 15);
    cyc("mdmis_go", MIS, 16);
    ex_mispredict = 1'b0;
    cyc("mdmis_nx", RUN, 16);

    // D-stall wins over mul/div while md_cnt keeps counting
    md_start = 1'b1; mem_req = 1'b1;
    cyc("dmd0", DST, 16);
    md_start = 1'b0;
    cyc("dmd1", DST, 17);
    dcache_resp = 1'b1;
    cyc("dmd2", MDS, 18);
    idle();
    cyc("dmd_done", RUN, 19);

    // Load-use outranks I-stall
    icache_resp = 1'b0; ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
    cyc("lu_ist", LU, 19);
    idle();
    cyc("lu_ist_nx", RUN, 20);

    // Reset during D-stall with mul/div counting abandons both
    md_start = 1'b1; mem_req = 1'b1;
    cyc("pre_rst", DST, 20);
    reset = 1'b1; md_start = 1'b0; mem_req = 1'b0;
    cyc("mid_rst", ZERO, 21);
    reset = 1'b0;
    cyc("post_rst0", RUN, 0);
    cyc("post_rst1", RUN, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
